joy_drp_scanner: RTL



---
 rtl/joy_pkg.sv | 20 ++
 rtl/joy_axis_hyst.sv | 58 +++++
 rtl/joy_drp_scanner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick DRP scanner.
//   state_t    : sequencer states (IDLE, REQ, WAIT, UPDATE)
//   DEF_ADDR_Y : default DRP address of the Y-axis channel (VAUX6)
//   DEF_ADDR_X : default DRP address of the X-axis channel (VAUX14)
//   level_t    : 4-bit axis level taken from the top nibble of a conversion
package joy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_UPDATE
    } state_t;

    localparam logic [6:0] DEF_ADDR_Y = 7'h16;
    localparam logic [6:0] DEF_ADDR_X = 7'h1E;

    typedef logic [3:0] level_t;

endpackage

// File: rtl/joy_axis_hyst.sv
// Per-axis hysteresis: turns a 4-bit level into a high and a low direction
// flag. The flags change only when upd is asserted; otherwise they hold.
//   clk, rst_n : clock, asynchronous active-low reset
//   upd        : evaluate the new level this cycle
//   level      : new 4-bit axis level
//   hi         : high-direction flag (up / right)
//   lo         : low-direction flag (down / left)
module joy_axis_hyst
    import joy_pkg::*;
#(
    parameter int unsigned HI_ON  = 10,
    parameter int unsigned HI_OFF = 8,
    parameter int unsigned LO_ON  = 1,
    parameter int unsigned LO_OFF = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   upd,
    input  level_t level,
    output logic   hi,
    output logic   lo
);

    localparam level_t HI_ON_L  = level_t'(HI_ON);
    localparam level_t HI_OFF_L = level_t'(HI_OFF);
    localparam level_t LO_ON_L  = level_t'(LO_ON);
    localparam level_t LO_OFF_L = level_t'(LO_OFF);

    // Between the on and off thresholds the previous flag value is kept.
    function automatic logic hi_next(input logic cur, input level_t l);
        if (l >= HI_ON_L)
            return 1'b1;
        else if (l <= HI_OFF_L)
            return 1'b0;
        else
            return cur;
    endfunction

    function automatic logic lo_next(input logic cur, input level_t l);
        if (l <= LO_ON_L)
            return 1'b1;
        else if (l >= LO_OFF_L)
            return 1'b0;
        else
            return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 1'b0;
            lo <= 1'b0;
        end else if (upd) begin
            hi <= hi_next(hi, level);
            lo <= lo_next(lo, level);
        end
    end

endmodule

// File: rtl/joy_drp_scanner.sv
// Joystick scanner: alternately reads the Y (VAUX6) and X (VAUX14) XADC
// channels over DRP, keeps the top nibble of each conversion as the axis
// level and derives up/down/right/left flags through hysteresis.
//   CLK100MHZ, clr_n     : clock, asynchronous active-low reset
//   daddr, den           : DRP address and one-cycle read enable
//   drdy, do_in          : DRP read-data strobe and data
//   vry, vrx             : latest Y / X levels
//   up, down, right, left: direction flags
//   sample_valid         : one-cycle strobe after an axis update
//   timeout_err          : sticky, set when drdy never arrives
module joy_drp_scanner
    import joy_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [6:0]  ADDR_Y        = DEF_ADDR_Y,
    parameter logic [6:0]  ADDR_X        = DEF_ADDR_X,
    parameter int unsigned HI_ON         = 10,
    parameter int unsigned HI_OFF        = 8,
    parameter int unsigned LO_ON         = 1,
    parameter int unsigned LO_OFF        = 3
) (
    input  logic        CLK100MHZ,
    input  logic        clr_n,
    output logic [6:0]  daddr,
    output logic        den,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [3:0]  vry,
    output logic [3:0]  vrx,
    output logic        up,
    output logic        down,
    output logic        right,
    output logic        left,
    output logic        sample_valid,
    output logic        timeout_err
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    state_t        state, state_n;
    logic [PW-1:0] per_cnt;
    logic          tick;
    logic [TW-1:0] to_cnt;
    logic          chan_x;      // 0 = Y channel selected, 1 = X channel
    logic          capture;
    logic          to_expire;
    level_t        new_level;
    logic          unused_bits;

    assign new_level = do_in[15:12];
    // Only the top nibble feeds the level; the rest of the conversion is dropped.
    assign unused_bits = ^do_in[11:0];

    // Address follows the channel select, which only moves in UPDATE, so it
    // is stable throughout REQ and WAIT.
    assign daddr = chan_x ? ADDR_X : ADDR_Y;

    // Free-running period counter; tick is the registered wrap strobe.
    always_ff @(posedge CLK100MHZ or negedge clr_n) begin
        if (!clr_n) begin
            per_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (per_cnt == PER_LAST);
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PW'(1);
        end
    end

    always_comb begin
        state_n      = state;
        den          = 1'b0;
        sample_valid = 1'b0;
        capture      = 1'b0;
        to_expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick)
                    state_n = ST_REQ;
            end
            ST_REQ: begin
                den     = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // drdy takes priority over an expiring timeout in the same cycle.
                if (drdy) begin
                    capture = 1'b1;
                    state_n = ST_UPDATE;
                end else if (to_cnt == TO_LAST) begin
                    to_expire = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                sample_valid = 1'b1;
                state_n      = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge clr_n) begin
        if (!clr_n) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            chan_x      <= 1'b0;
            timeout_err <= 1'b0;
            vry         <= '0;
            vrx         <= '0;
        end else begin
            state <= state_n;
            if (state == ST_REQ)
                to_cnt <= '0;
            else if (state == ST_WAIT && !drdy)
                to_cnt <= to_cnt + TW'(1);
            if (to_expire)
                timeout_err <= 1'b1;
            if (state == ST_UPDATE)
                chan_x <= ~chan_x;
            if (capture && !chan_x)
                vry <= new_level;
            if (capture && chan_x)
                vrx <= new_level;
        end
    end

    // Flags are evaluated on the capture edge so they appear together with
    // the new level and the sample_valid strobe.
    joy_axis_hyst #(
        .HI_ON (HI_ON),
        .HI_OFF(HI_OFF),
        .LO_ON (LO_ON),
        .LO_OFF(LO_OFF)
    ) u_hyst_y (
        .clk  (CLK100MHZ),
        .rst_n(clr_n),
        .upd  (capture & ~chan_x),
        .level(new_level),
        .hi   (up),
        .lo   (down)
    );

    joy_axis_hyst #(
        .HI_ON (HI_ON),
        .HI_OFF(HI_OFF),
        .LO_ON (LO_ON),
        .LO_OFF(LO_OFF)
    ) u_hyst_x (
        .clk  (CLK100MHZ),
        .rst_n(clr_n),
        .upd  (capture & chan_x),
        .level(new_level),
        .hi   (right),
        .lo   (left)
    );

endmodule
